// File: rtl/arrow_pkg.sv
// Shared types and constants for the arrow playfield: slot record, scheduler
// states, lane count and the lane colours used by the VGA colour mapper.
package arrow_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;
  localparam int Y_W       = 10;
  localparam int SLOT_W    = 1 + LANE_W + Y_W;

  typedef struct packed {
    logic              valid;
    logic [LANE_W-1:0] lane;
    logic [Y_W-1:0]    y;
  } arrow_slot_t;

  typedef enum logic [1:0] {
    IDLE,
    SCROLL,
    CLEAR
  } sched_state_t;

  // 24-bit RGB per lane, index 0 is lane 0
  localparam logic [NUM_LANES-1:0][23:0] LANE_RGB = {
    24'hFFD700,
    24'h32CD32,
    24'h1E90FF,
    24'hFF4040
  };

  function automatic logic [NUM_LANES-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
    lane_onehot = NUM_LANES'(1) << lane;
  endfunction

endpackage

// File: rtl/arrow_slot_hit.sv
// Combinational pixel test for one slot: returns the lane one-hot when the
// current pixel lies inside that slot's arrow sprite, zero otherwise.
module arrow_slot_hit
  import arrow_pkg::*;
#(
  parameter logic [9:0] ARROW_SIZE = 10'd32,
  parameter logic [9:0] LANE_X0    = 10'd200,
  parameter logic [9:0] LANE_PITCH = 10'd48
) (
  input  logic [SLOT_W-1:0]    i_slot,
  input  logic [9:0]           i_draw_x,
  input  logic [9:0]           i_draw_y,
  output logic [NUM_LANES-1:0] o_lane_hit
);

  arrow_slot_t w_slot;
  logic [10:0] w_x0;
  logic [10:0] w_y0;
  logic [10:0] w_px;
  logic [10:0] w_py;
  logic        w_x_in;
  logic        w_y_in;

  assign w_slot = i_slot;

  // 11-bit extents so a sprite near the bottom/right edge never wraps to 0
  assign w_x0   = 11'(LANE_X0) + 11'(w_slot.lane) * 11'(LANE_PITCH);
  assign w_y0   = {1'b0, w_slot.y};
  assign w_px   = {1'b0, i_draw_x};
  assign w_py   = {1'b0, i_draw_y};
  assign w_x_in = (w_px >= w_x0) && (w_px < w_x0 + 11'(ARROW_SIZE));
  assign w_y_in = (w_py >= w_y0) && (w_py < w_y0 + 11'(ARROW_SIZE));

  assign o_lane_hit = (w_slot.valid && w_x_in && w_y_in) ? lane_onehot(w_slot.lane)
                                                         : '0;

endmodule

// File: rtl/arrow_scheduler.sv
// Active-arrow slot table for the 4-lane playfield, stepped once per frame.
// Optional hit counter on score is built only when ARROW_SCORE_EN is defined.
module arrow_scheduler
  import arrow_pkg::*;
#(
  parameter int         NUM_SLOTS  = 8,
  parameter logic [9:0] SPEED      = 10'd4,
  parameter logic [9:0] SPAWN_Y    = 10'd479,
  parameter logic [9:0] RECEPTOR_Y = 10'd40,
  parameter logic [9:0] WINDOW     = 10'd12,
  parameter logic [9:0] ARROW_SIZE = 10'd32,
  parameter logic [9:0] LANE_X0    = 10'd200,
  parameter logic [9:0] LANE_PITCH = 10'd48
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_clk,
  input  logic        spawn_valid,
  input  logic [1:0]  spawn_lane,
  output logic        spawn_ready,
  input  logic [3:0]  key_hit,
  input  logic [9:0]  DrawX,
  input  logic [9:0]  DrawY,
  output logic [3:0]  display_arrow,
  output logic        hit_pulse,
  output logic        miss_pulse,
  output logic [15:0] score
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  arrow_slot_t              r_slots [NUM_SLOTS];
  sched_state_t             r_state;
  logic [IDX_W-1:0]         r_idx;
  logic [NUM_LANES-1:0]     r_latch;
  logic                     r_frame_d;
  logic                     r_hit_pulse;
  logic                     r_miss_pulse;

  logic                     w_tick;
  logic                     w_any_free;
  logic [IDX_W-1:0]         w_free_idx;
  logic                     w_spawn_fire;
  arrow_slot_t              w_cur;
  logic signed [10:0]       w_ny;
  logic signed [10:0]       w_diff;
  logic signed [10:0]       w_abs;
  logic                     w_in_win;
  logic                     w_below;
  logic                     w_judge_hit;
  logic                     w_judge_miss;
  logic [NUM_LANES-1:0]     w_latch_next;
  logic [NUM_LANES-1:0]     w_slot_hit [NUM_SLOTS];
  logic [NUM_LANES-1:0]     w_disp;

  assign w_tick = frame_clk & ~r_frame_d;

  always_comb begin
    w_any_free = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!r_slots[i].valid) begin
        w_any_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign spawn_ready  = ~Reset & (r_state == IDLE) & w_any_free & ~w_tick;
  assign w_spawn_fire = spawn_valid & spawn_ready;

  // Judgement of the slot visited this SCROLL cycle, in signed 11 bits
  assign w_cur        = r_slots[r_idx];
  assign w_ny         = $signed({1'b0, w_cur.y}) - $signed({1'b0, SPEED});
  assign w_diff       = w_ny - $signed({1'b0, RECEPTOR_Y});
  assign w_abs        = (w_diff < 0) ? -w_diff : w_diff;
  assign w_in_win     = (w_abs <= $signed({1'b0, WINDOW}));
  assign w_below      = (w_ny < ($signed({1'b0, RECEPTOR_Y}) - $signed({1'b0, WINDOW})));
  assign w_judge_hit  = w_cur.valid & r_latch[w_cur.lane] & w_in_win;
  assign w_judge_miss = w_cur.valid & ~w_judge_hit & w_below;

  // A press consumed by a hit is dropped, a fresh press still lands, CLEAR wins
  always_comb begin
    w_latch_next = r_latch;
    if (r_state == SCROLL && w_judge_hit) begin
      w_latch_next[w_cur.lane] = 1'b0;
    end
    w_latch_next = w_latch_next | key_hit;
    if (r_state == CLEAR) begin
      w_latch_next = '0;
    end
  end

  always_ff @(posedge Clk) begin
    // Edge detector keeps tracking the level through reset so a held-high
    // frame_clk does not look like a fresh edge afterwards.
    r_frame_d <= frame_clk;
    if (Reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_latch      <= '0;
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        r_slots[i] <= '0;
      end
    end else begin
      r_hit_pulse  <= 1'b0;
      r_miss_pulse <= 1'b0;
      r_latch      <= w_latch_next;
      case (r_state)
        IDLE: begin
          if (w_tick) begin
            r_state <= SCROLL;
            r_idx   <= '0;
          end
          if (w_spawn_fire) begin
            r_slots[w_free_idx] <= arrow_slot_t'{valid: 1'b1, lane: spawn_lane, y: SPAWN_Y};
          end
        end
        SCROLL: begin
          if (w_cur.valid) begin
            if (w_judge_hit) begin
              r_slots[r_idx].valid <= 1'b0;
              r_hit_pulse          <= 1'b1;
            end else if (w_judge_miss) begin
              r_slots[r_idx].valid <= 1'b0;
              r_miss_pulse         <= 1'b1;
            end else begin
              r_slots[r_idx].y <= w_ny[9:0];
            end
          end
          if (r_idx == LAST_IDX) begin
            r_state <= CLEAR;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        CLEAR: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign hit_pulse  = r_hit_pulse;
  assign miss_pulse = r_miss_pulse;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_hit
      arrow_slot_hit #(
        .ARROW_SIZE (ARROW_SIZE),
        .LANE_X0    (LANE_X0),
        .LANE_PITCH (LANE_PITCH)
      ) u_slot_hit (
        .i_slot     (r_slots[gi]),
        .i_draw_x   (DrawX),
        .i_draw_y   (DrawY),
        .o_lane_hit (w_slot_hit[gi])
      );
    end
  endgenerate

  always_comb begin
    w_disp = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      w_disp = w_disp | w_slot_hit[i];
    end
  end

  assign display_arrow = w_disp;

`ifdef ARROW_SCORE_EN
  logic [15:0] r_score;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_score <= '0;
    end else if (r_hit_pulse && r_score != 16'hFFFF) begin
      r_score <= r_score + 16'd1;
    end
  end

  assign score = r_score;
`else
  assign score = 16'h0000;
`endif

endmodule

// File: tb/tb_arrow_scheduler.sv
// Directed bench for arrow_scheduler: spawn/scroll/hit/miss/reset scenarios
// with hand-computed frame counts, pulse timing and sprite coverage.
module tb_arrow_scheduler;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic        spawn_valid = 1'b0;
  logic [1:0]  spawn_lane = 2'd0;
  logic        spawn_ready;
  logic [3:0]  key_hit = 4'd0;
  logic [9:0]  DrawX = 10'd0;
  logic [9:0]  DrawY = 10'd0;
  logic [3:0]  display_arrow;
  logic        hit_pulse;
  logic        miss_pulse;
  logic [15:0] score;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  arrow_scheduler dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .frame_clk     (frame_clk),
    .spawn_valid   (spawn_valid),
    .spawn_lane    (spawn_lane),
    .spawn_ready   (spawn_ready),
    .key_hit       (key_hit),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .display_arrow (display_arrow),
    .hit_pulse     (hit_pulse),
    .miss_pulse    (miss_pulse),
    .score         (score)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic spawn(input logic [1:0] lane, input logic exp_ready, input string tag);
    @(negedge Clk);
    spawn_valid = 1'b1;
    spawn_lane  = lane;
    #1 chk(tag, spawn_ready, exp_ready);
    @(negedge Clk);
    spawn_valid = 1'b0;
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic [3:0] exp);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    #1 chk(tag, display_arrow, exp);
  endtask

  task automatic press(input logic [3:0] keys);
    @(negedge Clk);
    key_hit = keys;
    @(negedge Clk);
    key_hit = 4'd0;
  endtask

  // One frame pass; c counts negedges after the tick cycle (c=0).
  task automatic do_frame(input logic chk_tick, output int nh, output int nm,
                          output int hc, output int mc, output int an, output int ac);
    logic drop;
    nh = 0; nm = 0; an = 0;
    hc = -1; mc = -1; ac = -1;
    drop = 1'b0;
    @(negedge Clk);
    frame_clk = 1'b1;
    if (chk_tick) begin
      #1 chk("ready_in_tick_cycle", spawn_ready, 1'b0);
    end
    for (int c = 1; c <= 11; c++) begin
      @(negedge Clk);
      if (drop) begin
        spawn_valid = 1'b0;
        drop = 1'b0;
      end
      if (c == 11) frame_clk = 1'b0;
      if (hit_pulse) begin
        if (hc < 0) hc = c;
        nh++;
      end
      if (miss_pulse) begin
        if (mc < 0) mc = c;
        nm++;
      end
      if (spawn_valid && spawn_ready) begin
        if (ac < 0) ac = c;
        an++;
        drop = 1'b1;
      end
    end
    if (drop) begin
      @(negedge Clk);
      spawn_valid = 1'b0;
    end
  endtask

  task automatic run_quiet(input int n, output int pulses);
    int nh, nm, hc, mc, an, ac;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      do_frame(1'b0, nh, nm, hc, mc, an, ac);
      pulses += nh + nm + an;
    end
  endtask

  initial begin
    int nh, nm, hc, mc, an, ac;
    int pulses, frames, found, bad, not_ready;

    // 1: reset state, spawn lane 2, one scroll step
    repeat (2) @(negedge Clk);
    #1 chk("ready_during_reset", spawn_ready, 1'b0);
    Reset = 1'b0;
    DrawX = 10'd296;
    DrawY = 10'd479;
    #1 chk("reset_ready", spawn_ready, 1'b1);
    chk("reset_pulses", {hit_pulse, miss_pulse}, 2'b00);
    chk("reset_score", score, 16'd0);
    chk("reset_display", display_arrow, 4'b0000);
    spawn(2'd2, 1'b1, "t1_spawn_ready");
    probe("t1_disp_origin", 296, 479, 4'b0100);
    probe("t1_disp_left_out", 295, 479, 4'b0000);
    probe("t1_disp_far_corner", 327, 510, 4'b0100);
    probe("t1_disp_right_out", 328, 479, 4'b0000);
    probe("t1_disp_bottom_out", 296, 511, 4'b0000);
    do_frame(1'b1, nh, nm, hc, mc, an, ac);
    chk("t1_frame_pulses", nh + nm, 0);
    probe("t1_disp_after_tick", 296, 475, 4'b0100);
    probe("t1_disp_above_out", 296, 474, 4'b0000);
    probe("t1_disp_new_bottom", 296, 506, 4'b0100);
    probe("t1_disp_new_bottom_out", 296, 507, 4'b0000);

    // 2: full table holds the 9th request until slot 0 misses
    do_reset();
    spawn(2'd0, 1'b1, "t2_spawn_slot0");
    do_frame(1'b0, nh, nm, hc, mc, an, ac);
    for (int i = 1; i < 8; i++) spawn(2'(i % 4), 1'b1, $sformatf("t2_spawn_slot%0d", i));
    @(negedge Clk);
    spawn_valid = 1'b1;
    spawn_lane  = 2'd1;
    #1 chk("t2_full_ready", spawn_ready, 1'b0);
    frames = 0; found = 0; pulses = 0;
    for (int k = 1; k <= 200 && found == 0; k++) begin
      do_frame(1'b0, nh, nm, hc, mc, an, ac);
      if (nm > 0) begin
        found  = 1;
        frames = k;
      end else begin
        pulses += nh + an;
      end
    end
    spawn_valid = 1'b0;
    chk("t2_frames_to_miss", frames, 112);
    chk("t2_quiet_before_miss", pulses, 0);
    chk("t2_miss_count", nm, 1);
    chk("t2_miss_slot_cycle", mc, 2);
    chk("t2_accept_count", an, 1);
    chk("t2_accept_cycle", ac, 10);
    do_frame(1'b0, nh, nm, hc, mc, an, ac);
    chk("t2_rest_miss_count", nm, 7);
    chk("t2_rest_first_miss", mc, 3);
    chk("t2_rest_hits", nh, 0);
    probe("t2_new_arrow_disp", 248, 475, 4'b0010);

    // 3: slot 0 lane 1 at y=475; window edge, latch clear, then a hit
    run_quiet(104, pulses);
    chk("t3_quiet", pulses, 0);
    press(4'b0010);
    do_frame(1'b0, nh, nm, hc, mc, an, ac);
    chk("t3_out_of_window", nh + nm, 0);
    do_frame(1'b0, nh, nm, hc, mc, an, ac);
    chk("t3_latch_cleared", nh + nm, 0);
    press(4'b0010);
    do_frame(1'b0, nh, nm, hc, mc, an, ac);
    chk("t3_hit_count", nh, 1);
    chk("t3_hit_slot_cycle", hc, 2);
    chk("t3_no_miss", nm, 0);
`ifdef ARROW_SCORE_EN
    chk("t3_score", score, 16'd1);
`else
    chk("t3_score", score, 16'd0);
`endif
    probe("t3_slot_freed", 248, 51, 4'b0000);

    // 4: unpressed lane 0 arrow misses on frame 113
    spawn(2'd0, 1'b1, "t4_spawn");
    frames = 0; found = 0; pulses = 0;
    for (int k = 1; k <= 200 && found == 0; k++) begin
      do_frame(1'b0, nh, nm, hc, mc, an, ac);
      if (nm > 0) begin
        found  = 1;
        frames = k;
      end else begin
        pulses += nh;
      end
    end
    chk("t4_frames_to_miss", frames, 113);
    chk("t4_quiet", pulses, 0);
    chk("t4_miss_cycle", mc, 2);
    chk("t4_no_hit", nh, 0);
`ifdef ARROW_SCORE_EN
    chk("t4_score_held", score, 16'd1);
`else
    chk("t4_score_held", score, 16'd0);
`endif

    // 5: two lane 3 arrows in window (slots 1 and 4), one press
    do_reset();
    #1 chk("t5_score_reset", score, 16'd0);
    spawn(2'd0, 1'b1, "t5_spawn_slot0");
    spawn(2'd3, 1'b1, "t5_spawn_slot1");
    do_frame(1'b0, nh, nm, hc, mc, an, ac);
    spawn(2'd0, 1'b1, "t5_spawn_slot2");
    spawn(2'd0, 1'b1, "t5_spawn_slot3");
    spawn(2'd3, 1'b1, "t5_spawn_slot4");
    run_quiet(110, pulses);
    chk("t5_quiet", pulses, 0);
    press(4'b1000);
    do_frame(1'b0, nh, nm, hc, mc, an, ac);
    chk("t5_single_hit", nh, 1);
    chk("t5_hit_slot1_cycle", hc, 3);
    chk("t5_no_miss", nm, 0);
    probe("t5_slot4_kept", 344, 35, 4'b1000);
    probe("t5_slot4_top_out", 344, 34, 4'b0000);
    probe("t5_slot0_filler", 200, 31, 4'b0001);
    probe("t5_slot0_top_out", 200, 30, 4'b0000);
    do_frame(1'b0, nh, nm, hc, mc, an, ac);
    chk("t5_filler_miss", nm, 1);
    chk("t5_filler_miss_cycle", mc, 2);

    // 6: reset while SCROLL is on slot 3; frame_clk stays high afterwards
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (4) @(negedge Clk);
    chk("t6_miss_before_reset", miss_pulse, 1'b1);
    Reset = 1'b1;
    #1 chk("t6_ready_in_reset", spawn_ready, 1'b0);
    @(negedge Clk);
    chk("t6_pulses_after_reset", {hit_pulse, miss_pulse}, 2'b00);
    Reset = 1'b0;
    bad = 0;
    not_ready = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      if (hit_pulse || miss_pulse) bad++;
      if (!spawn_ready) not_ready++;
    end
    chk("t6_no_pulses", bad, 0);
    chk("t6_no_retick", not_ready, 0);
    probe("t6_table_cleared_l3", 344, 31, 4'b0000);
    probe("t6_table_cleared_l0", 200, 31, 4'b0000);
    frame_clk = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
